// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - multi-cycle data memory with stall, wrap-around indexing and misalignment flag
module data_mem_responder #(
    parameter int ADDR_BITS = 6,
    parameter int LATENCY   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        mem_stall,
    output logic        misaligned
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int         DEPTH  = 2 ** ADDR_BITS;
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    state_t                 r_state;
    state_t                 w_next_state;
    logic [3:0]             r_cnt;
    logic [ADDR_BITS+1:0]   r_addr;
    logic [31:0]            r_wdata;
    logic                   r_is_write;
    logic [31:0]            r_read_data;
    logic                   r_misaligned;
    logic [31:0]            r_mem [DEPTH];

    logic                   w_req;
    logic                   w_misaligned;
    logic [ADDR_BITS-1:0]   w_idx;
    logic                   w_unused;

    // Upper address bits only select aliases of the same word, so they are dropped.
    assign w_unused     = &{1'b0, address[31:ADDR_BITS+2]};
    assign w_req        = MemRead | MemWrite;
    assign w_misaligned = (r_addr[1:0] != 2'b00);
    assign w_idx        = r_addr[ADDR_BITS+1:2];

    assign readData   = r_read_data;
    assign misaligned = r_misaligned;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and stall decode; a request seen in DONE waits for the following IDLE.
    always_comb begin
        w_next_state = r_state;
        mem_stall    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_next_state = BUSY;
                    mem_stall    = 1'b1;
                end
            end
            BUSY: begin
                mem_stall = 1'b1;
                if (r_cnt == 4'd0) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Request capture, latency countdown and the memory access itself at BUSY exit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt        <= 4'd0;
            r_addr       <= '0;
            r_wdata      <= 32'd0;
            r_is_write   <= 1'b0;
            r_read_data  <= 32'd0;
            r_misaligned <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 32'd0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    r_misaligned <= 1'b0;
                    if (w_req) begin
                        r_addr     <= address[ADDR_BITS+1:0];
                        r_wdata    <= writeData;
                        r_is_write <= MemWrite;
                        r_cnt      <= LAT_M1;
                    end
                end
                BUSY: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_misaligned <= w_misaligned;
                        if (r_is_write) begin
                            if (!w_misaligned) begin
                                r_mem[w_idx] <= r_wdata;
                            end
                        end else begin
                            r_read_data <= w_misaligned ? 32'd0 : r_mem[w_idx];
                        end
                    end
                end
                DONE: begin
                    r_misaligned <= 1'b0;
                end
                default: begin
                    r_misaligned <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - scoreboard bench for data_mem_responder at LATENCY 2 and 4
module tb_data_mem_responder;

    typedef struct {
        logic [31:0] rd;
        logic        mis;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        rd    [2];
    logic        wr    [2];
    logic [31:0] addr  [2];
    logic [31:0] wd    [2];
    logic [31:0] rdata [2];
    logic        stall [2];
    logic        mis   [2];

    logic [31:0] exp_mem [2][64];
    logic [31:0] exp_rd  [2];
    exp_t        sb [$];
    int          n_cmp;
    int          n_fail;

    data_mem_responder #(.ADDR_BITS(6), .LATENCY(2)) dut2 (
        .clk       (clk),
        .reset     (reset),
        .MemRead   (rd[0]),
        .MemWrite  (wr[0]),
        .address   (addr[0]),
        .writeData (wd[0]),
        .readData  (rdata[0]),
        .mem_stall (stall[0]),
        .misaligned(mis[0])
    );

    data_mem_responder #(.ADDR_BITS(6), .LATENCY(4)) dut4 (
        .clk       (clk),
        .reset     (reset),
        .MemRead   (rd[1]),
        .MemWrite  (wr[1]),
        .address   (addr[1]),
        .writeData (wd[1]),
        .readData  (rdata[1]),
        .mem_stall (stall[1]),
        .misaligned(mis[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int s = 0; s < 2; s++) begin
            exp_rd[s] = 32'd0;
            for (int i = 0; i < 64; i++) exp_mem[s][i] = 32'd0;
        end
    endtask

    // One access on DUT sel: model updated, expectation queued, stall counted, result popped in DONE.
    task automatic access(input int sel, input bit w, input bit r,
                          input logic [31:0] a, input logic [31:0] d, input bit drop);
        exp_t        e;
        int          n;
        int          lat;
        logic [5:0]  idx;
        bit          m;
        idx = a[7:2];
        m   = (a[1:0] != 2'b00);
        lat = (sel == 0) ? 2 : 4;
        if (w) begin
            if (!m) exp_mem[sel][idx] = d;
        end else if (r) begin
            exp_rd[sel] = m ? 32'd0 : exp_mem[sel][idx];
        end
        e.rd  = exp_rd[sel];
        e.mis = m;
        sb.push_back(e);

        @(negedge clk);
        rd[sel] = r; wr[sel] = w; addr[sel] = a; wd[sel] = d;
        #1;
        n = 0;
        while (stall[sel] && n < 50) begin
            check("mis_while_stalled", {31'd0, mis[sel]}, 32'd0);
            n++;
            @(negedge clk);
            if (drop && n == 1) begin
                rd[sel] = 1'b0; wr[sel] = 1'b0; addr[sel] = 32'hFFFF_FFFF; wd[sel] = 32'h0BAD_0BAD;
            end
            #1;
        end
        check("stall_cycles", 32'(n), 32'(lat + 1));
        e = sb.pop_front();
        check("readData_done", rdata[sel], e.rd);
        check("misaligned_done", {31'd0, mis[sel]}, {31'd0, e.mis});
        rd[sel] = 1'b0; wr[sel] = 1'b0;
        @(negedge clk);
        #1;
        check("idle_stall", {31'd0, stall[sel]}, 32'd0);
        check("idle_misaligned", {31'd0, mis[sel]}, 32'd0);
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        for (int s = 0; s < 2; s++) begin
            rd[s] = 1'b0; wr[s] = 1'b0; addr[s] = 32'd0; wd[s] = 32'd0;
        end
        clear_model();
        reset = 1'b0;
        #1;
        for (int s = 0; s < 2; s++) begin
            check("reset_stall", {31'd0, stall[s]}, 32'd0);
            check("reset_readData", rdata[s], 32'd0);
            check("reset_misaligned", {31'd0, mis[s]}, 32'd0);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Aligned write then read.
        access(0, 1, 0, 32'h10, 32'hDEADBEEF, 0);
        access(0, 0, 1, 32'h10, 32'h0, 0);
        // Wrap-around aliasing.
        access(0, 1, 0, 32'h104, 32'h12345678, 0);
        access(0, 0, 1, 32'h004, 32'h0, 0);
        // Misaligned write, aligned read, misaligned read after a nonzero read.
        access(0, 1, 0, 32'h21, 32'hFFFFFFFF, 0);
        access(0, 0, 1, 32'h20, 32'h0, 0);
        access(0, 0, 1, 32'h10, 32'h0, 0);
        access(0, 0, 1, 32'h22, 32'h0, 0);
        // Read and write together act as a write.
        access(0, 0, 1, 32'h10, 32'h0, 0);
        access(0, 1, 1, 32'h8, 32'hA5A5A5A5, 0);
        access(0, 0, 1, 32'h8, 32'h0, 0);
        // Write with request dropped after acceptance still lands.
        access(0, 1, 0, 32'h2C, 32'h600DF00D, 1);
        access(0, 0, 1, 32'h2C, 32'h0, 0);

        // Reset one cycle into BUSY of a write.
        @(negedge clk);
        wr[0] = 1'b1; addr[0] = 32'hC; wd[0] = 32'h55;
        @(negedge clk);
        wr[0] = 1'b0;
        reset = 1'b0;
        #1;
        check("midreset_stall", {31'd0, stall[0]}, 32'd0);
        check("midreset_readData", rdata[0], 32'd0);
        check("midreset_misaligned", {31'd0, mis[0]}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        clear_model();
        access(0, 0, 1, 32'hC, 32'h0, 0);
        access(0, 0, 1, 32'h8, 32'h0, 0);

        // LATENCY=4 instance: read with request dropped and address changed mid-BUSY.
        access(1, 1, 0, 32'h30, 32'hCAFEF00D, 0);
        access(1, 0, 1, 32'h30, 32'h0, 1);
        access(1, 0, 1, 32'h33, 32'h0, 1);

        if (sb.size() != 0) check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
